// File: rtl/fifo_read_checker.sv
// Read-domain sink for the async FIFO: checks the arithmetic test stream,
// accumulates per-frame checksums and tracks starvation of the read side.
module fifo_read_checker #(
    parameter int W          = 16,
    parameter int STEP       = 5,
    parameter int FRAME_LEN  = 8,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 16
) (
    input  logic             read_clk,
    input  logic             reset_n,
    input  logic [W-1:0]     fifo_data,
    input  logic             fifo_empty,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [W-1:0]     last_word,
    output logic             frame_valid,
    output logic [W-1:0]     frame_sum,
    output logic             starve_flag,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_STARVED = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    localparam logic [W-1:0]     STEP_C   = W'(STEP);
    localparam logic [7:0]       FLEN_C   = 8'(FRAME_LEN);
    localparam logic [7:0]       SLIM_C   = 8'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [W-1:0]     exp_q, exp_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [W-1:0]     last_word_q, last_word_d;
    logic             frame_valid_q, frame_valid_d;
    logic [W-1:0]     frame_sum_q, frame_sum_d;
    logic             accept_s;
    logic [W-1:0]     acc_sum_s;
    logic [7:0]       fcnt_inc_s;
    logic [7:0]       ecnt_inc_s;

    assign accept_s   = ~fifo_empty;
    assign acc_sum_s  = acc_q + fifo_data;
    assign fcnt_inc_s = fcnt_q + 8'd1;
    assign ecnt_inc_s = ecnt_q + 8'd1;

    // Next-state logic for the checker datapath, frame accumulator and FSM.
    always_comb begin
        state_d         = state_q;
        exp_d           = exp_q;
        acc_d           = acc_q;
        fcnt_d          = fcnt_q;
        ecnt_d          = ecnt_q;
        word_count_d    = word_count_q;
        err_count_d     = err_count_q;
        err_flag_d      = err_flag_q;
        first_err_idx_d = first_err_idx_q;
        last_word_d     = last_word_q;
        frame_valid_d   = 1'b0;
        frame_sum_d     = frame_sum_q;

        if (accept_s) begin
            // Match or mismatch, the next expectation follows the received word.
            exp_d       = fifo_data + STEP_C;
            last_word_d = fifo_data;
            if (word_count_q != CNT_MAX) begin
                word_count_d = word_count_q + CNT_ONE;
            end else begin
                word_count_d = word_count_q;
            end
            if (fifo_data != exp_q) begin
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + CNT_ONE;
                end else begin
                    err_count_d = err_count_q;
                end
                if (!err_flag_q) begin
                    err_flag_d      = 1'b1;
                    first_err_idx_d = word_count_q;
                end else begin
                    err_flag_d      = err_flag_q;
                end
            end else begin
                err_count_d = err_count_q;
            end
            if (fcnt_inc_s == FLEN_C) begin
                frame_sum_d   = acc_sum_s;
                frame_valid_d = 1'b1;
                acc_d         = {W{1'b0}};
                fcnt_d        = 8'd0;
            end else begin
                acc_d         = acc_sum_s;
                fcnt_d        = fcnt_inc_s;
            end
        end else begin
            exp_d = exp_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ACTIVE;
                    ecnt_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_s) begin
                    ecnt_d = 8'd0;
                end else if (ecnt_inc_s >= SLIM_C) begin
                    ecnt_d  = ecnt_inc_s;
                    state_d = ST_STARVED;
                end else begin
                    ecnt_d = ecnt_inc_s;
                end
            end
            ST_STARVED: begin
                if (accept_s) begin
                    state_d = ST_ACTIVE;
                    ecnt_d  = 8'd0;
                end else begin
                    state_d = ST_STARVED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ecnt_d  = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge read_clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            exp_q           <= {W{1'b0}};
            acc_q           <= {W{1'b0}};
            fcnt_q          <= 8'd0;
            ecnt_q          <= 8'd0;
            word_count_q    <= {CNT_W{1'b0}};
            err_count_q     <= {CNT_W{1'b0}};
            err_flag_q      <= 1'b0;
            first_err_idx_q <= {CNT_W{1'b0}};
            last_word_q     <= {W{1'b0}};
            frame_valid_q   <= 1'b0;
            frame_sum_q     <= {W{1'b0}};
        end else begin
            state_q         <= state_d;
            exp_q           <= exp_d;
            acc_q           <= acc_d;
            fcnt_q          <= fcnt_d;
            ecnt_q          <= ecnt_d;
            word_count_q    <= word_count_d;
            err_count_q     <= err_count_d;
            err_flag_q      <= err_flag_d;
            first_err_idx_q <= first_err_idx_d;
            last_word_q     <= last_word_d;
            frame_valid_q   <= frame_valid_d;
            frame_sum_q     <= frame_sum_d;
        end
    end

    assign word_count    = word_count_q;
    assign err_count     = err_count_q;
    assign err_flag      = err_flag_q;
    assign first_err_idx = first_err_idx_q;
    assign last_word     = last_word_q;
    assign frame_valid   = frame_valid_q;
    assign frame_sum     = frame_sum_q;
    assign starve_flag   = (state_q == ST_STARVED);
    assign state         = state_q;

endmodule

// File: tb/tb_fifo_read_checker.sv
// Directed self-checking bench for fifo_read_checker (default parameters).
module tb_fifo_read_checker;

    logic        read_clk = 1'b0;
    logic        reset_n;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic        err_flag;
    logic [15:0] first_err_idx;
    logic [15:0] last_word;
    logic        frame_valid;
    logic [15:0] frame_sum;
    logic        starve_flag;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;
    int pulses;

    fifo_read_checker dut (
        .read_clk      (read_clk),
        .reset_n       (reset_n),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .word_count    (word_count),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .first_err_idx (first_err_idx),
        .last_word     (last_word),
        .frame_valid   (frame_valid),
        .frame_sum     (frame_sum),
        .starve_flag   (starve_flag),
        .state         (state)
    );

    always #5 read_clk = ~read_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        fifo_empty = 1'b0;
        fifo_data  = d;
        tick();
    endtask

    task automatic starve_cycle();
        fifo_empty = 1'b1;
        fifo_data  = 16'hDEAD;
        tick();
    endtask

    task automatic do_reset(input int cycles);
        reset_n    = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 16'h1234;
        for (int i = 0; i < cycles; i++) tick();
        reset_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 16'h1234;
        #2;

        // Reset held 3 cycles with a word presented
        do_reset(3);
        check("rst_word_count", word_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_first_err_idx", first_err_idx, 0);
        check("rst_last_word", last_word, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_sum", frame_sum, 0);
        check("rst_starve_flag", starve_flag, 0);
        check("rst_state", state, 0);

        // Empty cycles in IDLE are not counted
        for (int i = 0; i < 6; i++) starve_cycle();
        check("idle_stays_idle", state, 0);

        // Clean stream 0..75
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            push(16'(5 * i));
            if (frame_valid) pulses++;
            if (i == 0) check("first_accept_active", state, 1);
            if (i == 6) check("no_frame_at_7", frame_valid, 0);
            if (i == 7) begin
                check("frame1_valid", frame_valid, 1);
                check("frame1_sum", frame_sum, 140);
            end
            if (i == 8) begin
                check("frame1_pulse_ends", frame_valid, 0);
                check("frame_sum_held", frame_sum, 140);
            end
            if (i == 15) begin
                check("frame2_valid", frame_valid, 1);
                check("frame2_sum", frame_sum, 460);
            end
        end
        check("clean_pulses", pulses, 2);
        check("clean_word_count", word_count, 16);
        check("clean_err_count", err_count, 0);
        check("clean_err_flag", err_flag, 0);
        check("clean_last_word", last_word, 75);

        // Mismatch with resync
        do_reset(1);
        push(16'd0);
        push(16'd5);
        push(16'd99);
        check("mm_err_count", err_count, 1);
        check("mm_err_flag", err_flag, 1);
        check("mm_first_idx", first_err_idx, 2);
        push(16'd104);
        push(16'd109);
        check("resync_err_count", err_count, 1);
        check("resync_word_count", word_count, 5);
        check("resync_first_idx", first_err_idx, 2);
        check("resync_last_word", last_word, 109);

        // Wrap-around across 2^16
        do_reset(1);
        push(16'd65530);
        check("wrap_first_err", err_count, 1);
        check("wrap_first_idx", first_err_idx, 0);
        push(16'd65535);
        push(16'd4);
        push(16'd9);
        check("wrap_err_count", err_count, 1);
        check("wrap_word_count", word_count, 4);
        check("wrap_err_flag", err_flag, 1);

        // Starvation
        do_reset(1);
        push(16'd0);
        push(16'd5);
        push(16'd10);
        starve_cycle();
        starve_cycle();
        starve_cycle();
        check("starve_3_active", state, 1);
        check("starve_3_flag", starve_flag, 0);
        starve_cycle();
        check("starve_4_state", state, 2);
        check("starve_4_flag", starve_flag, 1);
        starve_cycle();
        check("starve_holds", state, 2);
        push(16'd15);
        check("unstarve_state", state, 1);
        check("unstarve_flag", starve_flag, 0);
        check("unstarve_word_processed", word_count, 4);
        check("unstarve_no_err", err_count, 0);
        starve_cycle();
        starve_cycle();
        starve_cycle();
        push(16'd20);
        check("three_empty_active", state, 1);
        starve_cycle();
        starve_cycle();
        starve_cycle();
        check("ecnt_cleared_by_accept", state, 1);

        // Reset mid-starve then mid-frame
        starve_cycle();
        check("restarve_state", state, 2);
        do_reset(1);
        check("midstarve_rst_state", state, 0);
        check("midstarve_rst_flag", starve_flag, 0);
        for (int i = 0; i < 5; i++) push(16'(5 * i));
        do_reset(1);
        check("midframe_rst_words", word_count, 0);
        check("midframe_rst_state", state, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            push(16'(5 * i));
            if (frame_valid) pulses++;
            if (i == 2) check("no_frame_at_3rd", frame_valid, 0);
        end
        check("midframe_pulses", pulses, 1);
        check("midframe_sum", frame_sum, 140);
        check("midframe_err_count", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
